// File: rtl/arb_merge_if.sv
// rtl/arb_merge_if.sv - producer/consumer handshake bundle for arb_merge
interface arb_merge_if #(
  parameter int DATA_W = 32
);
  logic              Send_in_a;
  logic [DATA_W-1:0] Data_in_a;
  logic              Ack_in_a;
  logic              Send_in_b;
  logic [DATA_W-1:0] Data_in_b;
  logic              Ack_in_b;
  logic              Send_out;
  logic [DATA_W-1:0] Data_out;
  logic              Src_out;
  logic              Ack_out;
  logic              Full;

  // Environment side: drives both producers and the consumer acknowledge.
  modport master (
    output Send_in_a, Data_in_a, Send_in_b, Data_in_b, Ack_out,
    input  Ack_in_a, Ack_in_b, Send_out, Data_out, Src_out, Full
  );

  // Merge stage side.
  modport slave (
    input  Send_in_a, Data_in_a, Send_in_b, Data_in_b, Ack_out,
    output Ack_in_a, Ack_in_b, Send_out, Data_out, Src_out, Full
  );
endinterface

// File: rtl/arb_merge.sv
// rtl/arb_merge.sv - two-input round-robin merge into a tagged FIFO (ARB_MERGE_FIXED_PRIO_EN selects fixed A priority)
module arb_merge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic          CLK,
  input logic          MR,
  arb_merge_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  src_mem;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              win_a;
  logic              win_b;
  logic              ack_a;
  logic              ack_b;
  logic              push;
  logic              pop;
  logic              push_src;
  logic [DATA_W-1:0] push_data;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

`ifdef ARB_MERGE_FIXED_PRIO_EN
  // A always wins; B only gets through when A is silent.
  always_comb begin
    win_a = 1'b1;
    win_b = ~bus.Send_in_a;
  end
`else
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;
  last_t last_q;
  last_t last_d;

  // Round-robin pointer register; reset favours A on the first contention.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) last_q <= LAST_B;
    else    last_q <= last_d;
  end

  // Pointer follows the winner of each grant and holds otherwise.
  always_comb begin
    last_d = last_q;
    if (ack_a)      last_d = LAST_A;
    else if (ack_b) last_d = LAST_B;
  end

  // A lone requester wins; under contention the side not served last wins.
  always_comb begin
    win_a = ~bus.Send_in_b | (last_q == LAST_B);
    win_b = ~bus.Send_in_a | (last_q == LAST_A);
  end
`endif

  // Grant never looks at Ack_out, so a full FIFO refuses even with a pop pending.
  always_comb begin
    ack_a     = bus.Send_in_a & win_a & ~full & ~MR;
    ack_b     = bus.Send_in_b & win_b & ~full & ~MR;
    push      = ack_a | ack_b;
    push_src  = ack_b;
    push_data = ack_b ? bus.Data_in_b : bus.Data_in_a;
    pop       = ~empty & bus.Ack_out;
  end

  assign bus.Ack_in_a = ack_a;
  assign bus.Ack_in_b = ack_b;
  assign bus.Send_out = ~empty;
  assign bus.Full     = full;
  assign bus.Data_out = data_mem[rd_ptr];
  assign bus.Src_out  = src_mem[rd_ptr];

  // Slot storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      for (int i = 0; i < DEPTH; i++) data_mem[i] <= '0;
      src_mem <= '0;
    end else if (push) begin
      data_mem[wr_ptr] <= push_data;
      src_mem[wr_ptr]  <= push_src;
    end
  end

  // Pointers wrap naturally at DEPTH; count nets out a simultaneous push and pop.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_arb_merge.sv
// tb/tb_arb_merge.sv - directed self-checking bench for arb_merge
module tb_arb_merge;
  logic CLK;
  logic MR;
  int   total;
  int   bad;

  arb_merge_if #(.DATA_W(32)) bus ();

  arb_merge #(.DATA_W(32), .DEPTH(4)) dut (
    .CLK (CLK),
    .MR  (MR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.Send_in_a = 1'b0;
    bus.Send_in_b = 1'b0;
    bus.Data_in_a = '0;
    bus.Data_in_b = '0;
    bus.Ack_out   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    MR = 1'b1;
    tick();
    tick();
    MR = 1'b0;
  endtask

  logic [31:0] exp_d [6];
  logic        exp_s [6];
  logic [32:0] q [$];
  logic [32:0] e;
  logic [15:0] stall;
  int na, nb, pushes, oidx, acks_b, rcv;

  initial begin
    total = 0;
    bad   = 0;
    idle();
    MR = 1'b1;
    bus.Send_in_a = 1'b1;
    bus.Data_in_a = 32'h5;
    tick();
    check("rst_send_out", bus.Send_out, 1'b0);
    check("rst_full", bus.Full, 1'b0);
    check("rst_ack_a", bus.Ack_in_a, 1'b0);
    check("rst_ack_b", bus.Ack_in_b, 1'b0);
    check("rst_src", bus.Src_out, 1'b0);
    check("rst_data", bus.Data_out, 32'h0);
    idle();
    tick();
    MR = 1'b0;

    // Single channel stream
    bus.Ack_out = 1'b1;
    bus.Send_in_a = 1'b1;
    bus.Data_in_a = 32'h11;
    #1 check("sc_ack0", bus.Ack_in_a, 1'b1);
    check("sc_empty0", bus.Send_out, 1'b0);
    tick();
    bus.Data_in_a = 32'h22;
    #1 check("sc_ack1", bus.Ack_in_a, 1'b1);
    check("sc_d0", bus.Data_out, 32'h11);
    check("sc_s0", bus.Src_out, 1'b0);
    tick();
    bus.Data_in_a = 32'h33;
    #1 check("sc_ack2", bus.Ack_in_a, 1'b1);
    check("sc_d1", bus.Data_out, 32'h22);
    check("sc_s1", bus.Src_out, 1'b0);
    tick();
    bus.Send_in_a = 1'b0;
    #1 check("sc_ack3", bus.Ack_in_a, 1'b0);
    check("sc_d2", bus.Data_out, 32'h33);
    check("sc_s2", bus.Src_out, 1'b0);
    check("sc_v2", bus.Send_out, 1'b1);
    tick();
    check("sc_drained", bus.Send_out, 1'b0);

    // Reset mid-stream with 3 buffered
    idle();
    bus.Send_in_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Data_in_a = 32'h71 + i;
      tick();
    end
    check("mr_pre_send", bus.Send_out, 1'b1);
    check("mr_pre_data", bus.Data_out, 32'h71);
    MR = 1'b1;
    #1 check("mr_send_out", bus.Send_out, 1'b0);
    check("mr_full", bus.Full, 1'b0);
    check("mr_ack_a", bus.Ack_in_a, 1'b0);
    check("mr_ack_b", bus.Ack_in_b, 1'b0);
    check("mr_data", bus.Data_out, 32'h0);
    tick();
    MR = 1'b0;
    bus.Data_in_a = 32'h7A;
    #1 check("mr_rel_ack", bus.Ack_in_a, 1'b1);
    check("mr_rel_empty", bus.Send_out, 1'b0);
    tick();
    bus.Send_in_a = 1'b0;
    #1 check("mr_new_send", bus.Send_out, 1'b1);
    check("mr_new_data", bus.Data_out, 32'h7A);
    bus.Ack_out = 1'b1;
    tick();
    check("mr_no_stale", bus.Send_out, 1'b0);

    // Contention with continuous requests
    do_reset();
`ifdef ARB_MERGE_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) begin
      exp_d[i] = 32'hA0 + i;
      exp_s[i] = 1'b0;
    end
`else
    exp_d[0] = 32'hA0; exp_d[1] = 32'hB0; exp_d[2] = 32'hA1;
    exp_d[3] = 32'hB1; exp_d[4] = 32'hA2; exp_d[5] = 32'hB2;
    for (int i = 0; i < 6; i++) exp_s[i] = i[0];
`endif
    na = 0; nb = 0; pushes = 0; oidx = 0; acks_b = 0;
    for (int c = 0; c < 12; c++) begin
      bus.Send_in_a = (pushes < 6);
      bus.Send_in_b = (pushes < 6);
      bus.Data_in_a = 32'hA0 + na;
      bus.Data_in_b = 32'hB0 + nb;
      bus.Ack_out   = 1'b1;
      #1;
      check("ct_one_hot", bus.Ack_in_a & bus.Ack_in_b, 1'b0);
      if (bus.Send_out) begin
        if (oidx < 6) begin
          check("ct_data", bus.Data_out, exp_d[oidx]);
          check("ct_src", bus.Src_out, exp_s[oidx]);
        end else begin
          check("ct_extra", oidx, 6);
        end
        oidx++;
      end
      if (bus.Ack_in_a) na++;
      if (bus.Ack_in_b) begin nb++; acks_b++; end
      pushes += int'(bus.Ack_in_a) + int'(bus.Ack_in_b);
      tick();
    end
    check("ct_count", oidx, 6);
`ifdef ARB_MERGE_FIXED_PRIO_EN
    check("ct_b_acks", acks_b, 0);
`else
    check("ct_b_acks", acks_b, 3);
`endif

    // Fill to full with consumer stalled
    do_reset();
    bus.Send_in_a = 1'b1;
    na = 0;
    for (int c = 0; c < 6; c++) begin
      bus.Data_in_a = 32'h50 + na;
      #1 check("fu_ack", bus.Ack_in_a, (c < 4));
      if (bus.Ack_in_a) na++;
      tick();
      if (c == 3) check("fu_full_rise", bus.Full, 1'b1);
    end
    check("fu_full", bus.Full, 1'b1);
    check("fu_head", bus.Data_out, 32'h50);
    bus.Data_in_a = 32'h50 + na;
    bus.Ack_out = 1'b1;
    #1 check("fu_no_grant_on_pop", bus.Ack_in_a, 1'b0);
    tick();
    bus.Ack_out = 1'b0;
    #1 check("fu_full_clear", bus.Full, 1'b0);
    check("fu_head2", bus.Data_out, 32'h51);
    check("fu_fifth_ack", bus.Ack_in_a, 1'b1);
    tick();
    bus.Send_in_a = 1'b0;
    check("fu_full_again", bus.Full, 1'b1);
    bus.Ack_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("fu_drain", bus.Data_out, 32'h51 + i);
      tick();
    end
    check("fu_empty", bus.Send_out, 1'b0);

    // Simultaneous push and pop at count 2
    idle();
    bus.Send_in_a = 1'b1;
    bus.Data_in_a = 32'h61;
    tick();
    bus.Data_in_a = 32'h62;
    tick();
    bus.Data_in_a = 32'h63;
    bus.Ack_out = 1'b1;
    #1 check("pp_ack", bus.Ack_in_a, 1'b1);
    check("pp_head0", bus.Data_out, 32'h61);
    tick();
    bus.Send_in_a = 1'b0;
    #1 check("pp_send", bus.Send_out, 1'b1);
    check("pp_head1", bus.Data_out, 32'h62);
    tick();
    check("pp_head2", bus.Data_out, 32'h63);
    check("pp_send2", bus.Send_out, 1'b1);
    tick();
    check("pp_empty", bus.Send_out, 1'b0);

    // Wrap-around: 13 packets from both sides with consumer stalls
    do_reset();
    stall = 16'b1011_0110_1110_0101;
    na = 0; nb = 0; pushes = 0; rcv = 0;
    for (int c = 0; c < 120 && rcv < 13; c++) begin
      bus.Send_in_a = (pushes < 13);
      bus.Send_in_b = (pushes < 13) && (c % 3 != 0);
      bus.Data_in_a = 32'h100 + na;
      bus.Data_in_b = 32'h200 + nb;
      bus.Ack_out   = stall[c % 16];
      #1;
      if (bus.Send_out && bus.Ack_out) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("wr_data", bus.Data_out, e[31:0]);
          check("wr_src", bus.Src_out, e[32]);
        end else begin
          check("wr_unexpected", 1'b1, 1'b0);
        end
        rcv++;
      end
      if (bus.Ack_in_a) begin q.push_back({1'b0, bus.Data_in_a}); na++; end
      if (bus.Ack_in_b) begin q.push_back({1'b1, bus.Data_in_b}); nb++; end
      pushes += int'(bus.Ack_in_a) + int'(bus.Ack_in_b);
      tick();
    end
    check("wr_received", rcv, 13);
    check("wr_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
